// File: rtl/mem_lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: op codes, FSM encoding, bus widths.
package mem_lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [OP_W-1:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [OP_W-1:0] EXE_LB_OP   = 8'b1110_0000;
    localparam logic [OP_W-1:0] EXE_LH_OP   = 8'b1110_0001;
    localparam logic [OP_W-1:0] EXE_LW_OP   = 8'b1110_0011;
    localparam logic [OP_W-1:0] EXE_LBU_OP  = 8'b1110_0100;
    localparam logic [OP_W-1:0] EXE_LHU_OP  = 8'b1110_0101;
    localparam logic [OP_W-1:0] EXE_SB_OP   = 8'b1110_1000;
    localparam logic [OP_W-1:0] EXE_SH_OP   = 8'b1110_1001;
    localparam logic [OP_W-1:0] EXE_SW_OP   = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_lsu_fmt.sv
// Big-endian lane formatting: store byte enables/replication, load extract/extend, misalign flags.
module mem_lsu_fmt
    import mem_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   i_aluop,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_reg2,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_ldata,
    output logic              o_adel,
    output logic              o_ades
);

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [SEL_W-1:0] w_bsel;
    logic [SEL_W-1:0] w_hsel;

    // Byte 0 lives in bits [31:24], so the shift grows as the address shrinks.
    assign w_byte = 8'(i_rdata >> {~i_addr_lo, 3'b000});
    assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    assign w_bsel = 4'b1000 >> i_addr_lo;
    assign w_hsel = i_addr_lo[1] ? 4'b0011 : 4'b1100;

    always_comb begin
        o_sel   = '0;
        o_wdata = i_reg2;
        o_ldata = i_rdata;
        o_adel  = 1'b0;
        o_ades  = 1'b0;
        case (i_aluop)
            EXE_LB_OP:  begin o_sel = w_bsel; o_ldata = {{24{w_byte[7]}}, w_byte}; end
            EXE_LBU_OP: begin o_sel = w_bsel; o_ldata = {24'd0, w_byte}; end
            EXE_LH_OP:  begin o_sel = w_hsel; o_ldata = {{16{w_half[15]}}, w_half}; o_adel = i_addr_lo[0]; end
            EXE_LHU_OP: begin o_sel = w_hsel; o_ldata = {16'd0, w_half}; o_adel = i_addr_lo[0]; end
            EXE_LW_OP:  begin o_sel = 4'b1111; o_adel = |i_addr_lo; end
            EXE_SB_OP:  begin o_sel = w_bsel; o_wdata = {4{i_reg2[7:0]}}; end
            EXE_SH_OP:  begin o_sel = w_hsel; o_wdata = {2{i_reg2[15:0]}}; o_ades = i_addr_lo[0]; end
            EXE_SW_OP:  begin o_sel = 4'b1111; o_ades = |i_addr_lo; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passthrough for ALU ops, single-beat req/ack bus cycle for loads/stores.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [REG_W-1:0]  mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [OP_W-1:0]   mem_aluop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    output logic [REG_W-1:0]  wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              bus_err,
    output logic              bus_cyc,
    output logic              bus_we,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    lsu_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_ldata;
    logic              r_valid;
    logic              r_bus_err;
    logic              r_bus_cyc;
    logic              r_bus_we;
    logic [SEL_W-1:0]  r_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;

    logic [SEL_W-1:0]  w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ldata;
    logic              w_adel;
    logic              w_ades;
    logic              w_load;
    logic              w_mem;
    logic              w_start;
    logic              w_timeout;
    logic [CNT_W-1:0]  w_cnt_nxt;

    mem_lsu_fmt u_fmt (
        .i_aluop   (mem_aluop),
        .i_addr_lo (mem_addr[1:0]),
        .i_reg2    (mem_reg2),
        .i_rdata   (bus_rdata),
        .o_sel     (w_sel),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata),
        .o_adel    (w_adel),
        .o_ades    (w_ades)
    );

    assign w_load    = is_load(mem_aluop);
    assign w_mem     = w_load | is_store(mem_aluop);
    assign w_start   = (r_state == ST_IDLE) && w_mem && !w_adel && !w_ades && !flush;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYC));

    // Transaction FSM; a flush seen while BUSY only poisons the result, the bus cycle runs to completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ldata     <= '0;
            r_valid     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_cyc   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_bus_cyc   <= 1'b1;
                        r_bus_we    <= !w_load;
                        r_bus_sel   <= w_sel;
                        r_bus_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_cnt       <= '0;
                        r_valid     <= 1'b1;
                        r_state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (flush) r_valid <= 1'b0;
                    if (bus_ack) begin
                        r_ldata   <= w_ldata;
                        r_bus_cyc <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (w_timeout) begin
                        r_bus_cyc <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_valid   <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Writeback and stall are combinational so passthrough ops cost no cycle.
    always_comb begin
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        stallreq = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem) begin
                    wb_wreg  = 1'b0;
                    stallreq = w_start;
                end
            end
            ST_BUSY: begin
                wb_wreg  = 1'b0;
                stallreq = 1'b1;
            end
            ST_DONE: begin
                wb_wreg = w_load && mem_wreg && r_valid && !flush;
                if (w_load) wb_wdata = r_ldata;
            end
            default: wb_wreg = 1'b0;
        endcase
    end

    assign exc_adel  = w_adel;
    assign exc_ades  = w_ades;
    assign bus_err   = r_bus_err;
    assign bus_cyc   = r_bus_cyc;
    assign bus_we    = r_bus_we;
    assign bus_sel   = r_bus_sel;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: passthrough, loads/stores with lane formatting, misalign, flush, timeout, reset.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;
    logic        exc_adel;
    logic        exc_ades;
    logic        bus_err;
    logic        bus_cyc;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;
    int n_stall;

    always #5 clk = ~clk;

    mem_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_reg2  (mem_reg2),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .stallreq  (stallreq),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .bus_err   (bus_err),
        .bus_cyc   (bus_cyc),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_aluop = op;
        mem_addr  = addr;
        mem_reg2  = reg2;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
    endtask

    // Drive ack in BUSY cycle number ack_after (never if negative); stop at the first non-stalled cycle.
    task automatic run_mem(input int ack_after, input logic [31:0] rdata, output int cyc, output int stl);
        int busy_idx = 0;
        int guard    = 0;
        cyc = 0;
        stl = 0;
        while (stallreq === 1'b1 && guard < 64) begin
            stl++;
            guard++;
            if (bus_cyc === 1'b1) begin
                cyc++;
                if (busy_idx == ack_after) begin
                    bus_ack   = 1'b1;
                    bus_rdata = rdata;
                end
                busy_idx++;
            end
            tick();
            bus_ack = 1'b0;
        end
        chk("run_bound", 32'(guard < 64), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_cyc",   32'(bus_cyc), 32'd0);
        chk("rst_we",    32'(bus_we), 32'd0);
        chk("rst_sel",   32'(bus_sel), 32'd0);
        chk("rst_addr",  bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_err",   32'(bus_err), 32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);

        // Passthrough
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        #1;
        chk("pt_wd",    32'(wb_wd), 32'd5);
        chk("pt_wreg",  32'(wb_wreg), 32'd1);
        chk("pt_wdata", wb_wdata, 32'h1234);
        chk("pt_stall", 32'(stallreq), 32'd0);
        tick();
        chk("pt_cyc",   32'(bus_cyc), 32'd0);

        // LW with two wait cycles
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd3, 1'b1, 32'h0);
        #1;
        run_mem(2, 32'hDEADBEEF, n_cyc, n_stall);
        chk("lw_cyc_cnt",   32'(n_cyc), 32'd3);
        chk("lw_stall_cnt", 32'(n_stall), 32'd4);
        chk("lw_sel",       32'(bus_sel), 32'hF);
        chk("lw_addr",      bus_addr, 32'h100);
        chk("lw_wdata",     wb_wdata, 32'hDEADBEEF);
        chk("lw_wreg",      32'(wb_wreg), 32'd1);
        chk("lw_wd",        32'(wb_wd), 32'd3);
        chk("lw_cyc_done",  32'(bus_cyc), 32'd0);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // LB sign-extend, byte lane 3
        set_op(EXE_LB_OP, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0);
        #1;
        run_mem(0, 32'h112233F0, n_cyc, n_stall);
        chk("lb_stall_cnt", 32'(n_stall), 32'd2);
        chk("lb_sel",       32'(bus_sel), 32'h1);
        chk("lb_addr",      bus_addr, 32'h100);
        chk("lb_wdata",     wb_wdata, 32'hFFFFFFF0);
        chk("lb_wreg",      32'(wb_wreg), 32'd1);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // LBU zero-extend
        set_op(EXE_LBU_OP, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0);
        #1;
        run_mem(0, 32'h112233F0, n_cyc, n_stall);
        chk("lbu_wdata", wb_wdata, 32'h000000F0);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // LH sign-extend, low half
        set_op(EXE_LH_OP, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0);
        #1;
        run_mem(1, 32'h12348765, n_cyc, n_stall);
        chk("lh_sel",   32'(bus_sel), 32'h3);
        chk("lh_wdata", wb_wdata, 32'hFFFF8765);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // SH upper address half, store data replicated
        set_op(EXE_SH_OP, 32'h202, 32'h0000ABCD, 5'd7, 1'b1, 32'hAA);
        #1;
        chk("sh_stall_idle", 32'(stallreq), 32'd1);
        tick();
        chk("sh_cyc",   32'(bus_cyc), 32'd1);
        chk("sh_we",    32'(bus_we), 32'd1);
        chk("sh_sel",   32'(bus_sel), 32'h3);
        chk("sh_bwd",   bus_wdata, 32'hABCDABCD);
        chk("sh_addr",  bus_addr, 32'h200);
        chk("sh_wreg_busy", 32'(wb_wreg), 32'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("sh_wreg_done", 32'(wb_wreg), 32'd0);
        chk("sh_stall_done", 32'(stallreq), 32'd0);
        chk("sh_we_done", 32'(bus_we), 32'd0);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // Misaligned load and store
        set_op(EXE_LW_OP, 32'h101, 32'h0, 5'd8, 1'b1, 32'h0);
        #1;
        chk("adel",       32'(exc_adel), 32'd1);
        chk("adel_ades",  32'(exc_ades), 32'd0);
        chk("adel_stall", 32'(stallreq), 32'd0);
        chk("adel_wreg",  32'(wb_wreg), 32'd0);
        tick();
        chk("adel_cyc",   32'(bus_cyc), 32'd0);
        set_op(EXE_SW_OP, 32'h102, 32'h0, 5'd8, 1'b1, 32'h0);
        #1;
        chk("ades",       32'(exc_ades), 32'd1);
        chk("ades_stall", 32'(stallreq), 32'd0);
        tick();
        chk("ades_cyc",   32'(bus_cyc), 32'd0);

        // Flush in IDLE: nothing starts
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
        flush = 1'b1;
        #1;
        chk("fli_stall", 32'(stallreq), 32'd0);
        tick();
        chk("fli_cyc",   32'(bus_cyc), 32'd0);
        flush = 1'b0;
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // Flush coincident with ack in BUSY: result discarded
        set_op(EXE_LW_OP, 32'h100, 32'h0, 5'd9, 1'b1, 32'h0);
        #1;
        tick();
        chk("flb_cyc", 32'(bus_cyc), 32'd1);
        flush     = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'h55555555;
        tick();
        bus_ack = 1'b0;
        flush   = 1'b0;
        #1;
        chk("flb_stall", 32'(stallreq), 32'd0);
        chk("flb_wreg",  32'(wb_wreg), 32'd0);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();

        // Timeout: SW with no ack
        set_op(EXE_SW_OP, 32'h300, 32'hCAFEF00D, 5'd10, 1'b1, 32'h0);
        #1;
        run_mem(-1, 32'h0, n_cyc, n_stall);
        chk("to_cyc_cnt",   32'(n_cyc), 32'd4);
        chk("to_stall_cnt", 32'(n_stall), 32'd5);
        chk("to_err",       32'(bus_err), 32'd1);
        chk("to_cyc",       32'(bus_cyc), 32'd0);
        chk("to_wreg",      32'(wb_wreg), 32'd0);
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        chk("to_err_clr",   32'(bus_err), 32'd0);

        // Reset while BUSY
        set_op(EXE_SW_OP, 32'h300, 32'hCAFEF00D, 5'd10, 1'b1, 32'h0);
        #1;
        tick();
        tick();
        chk("rb_cyc_busy", 32'(bus_cyc), 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_cyc",   32'(bus_cyc), 32'd0);
        chk("rb_state", 32'(dut.r_state), 32'(ST_IDLE));
        set_op(EXE_ADDU_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        chk("rb_stall", 32'(stallreq), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM-stage load/store unit. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Non-memory instructions pass through combinationally.
- Loads and stores run a single-beat transaction on a req/ack data bus. The stage holds the pipeline with stallreq until the transaction completes.
- The unit formats load data (byte/half extract, sign or zero extend) and store lanes (big-endian), and flags misaligned accesses.

Parameters:
TIMEOUT_CYC, 255, ack wait limit in cycles while BUSY; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  pipeline flush; discard the current instruction's result
mem_wd  in  5  destination register address from EX/MEM
mem_wreg  in  1  write-enable from EX/MEM
mem_wdata  in  32  ALU result from EX/MEM
mem_aluop  in  8  operation code (`EXE_*_OP)
mem_addr  in  32  effective address
mem_reg2  in  32  store data
wb_wd  out  5  to MEM/WB
wb_wreg  out  1  to MEM/WB
wb_wdata  out  32  to MEM/WB
stallreq  out  1  stall request to the pipeline controller
exc_adel  out  1  misaligned load (combinational)
exc_ades  out  1  misaligned store (combinational)
bus_err  out  1  one-cycle pulse on timeout
bus_cyc  out  1  transaction active (registered)
bus_we  out  1  write (registered)
bus_sel  out  4  byte lanes; bit3 = bits[31:24] (registered)
bus_addr  out  32  word address; bits[1:0]=0 (registered)
bus_wdata  out  32  store data (registered)
bus_rdata  in  32  read data
bus_ack  in  1  completion; may assert in the first cycle bus_cyc is high

Behaviour:
Reset:
- bus_cyc, bus_we = 0; bus_sel, bus_addr, bus_wdata = 0.
- FSM = IDLE; timeout counter = 0; load latch = 0; bus_err = 0.
- A reset while BUSY drops bus_cyc the next cycle. No result is produced.

Operations:
- Memory ops: LB, LBU, LH, LHU, LW, SB, SH, SW.
- Any other aluop is passthrough: wb_* = mem_*, stallreq = 0, no bus activity.

Alignment:
- Halfword accesses need addr[0]=0; word accesses need addr[1:0]=0.
- A misaligned op raises exc_adel (load) or exc_ades (store) in the same cycle.
- It starts no bus cycle, drives wb_wreg = 0, and drives stallreq = 0.

Store lanes (big-endian):
- SB: sel = 4'b1000 >> addr[1:0]; wdata = the byte replicated 4 times.
- SH: sel = 1100 or 0011 for addr[1] = 0 or 1; wdata = the half replicated twice.
- SW: sel = 1111.
- Stores force wb_wreg = 0.

Load extract:
- The byte/half is selected by addr as for stores.
- LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.

FSM:
- IDLE: on an aligned memory op and !flush, register the bus outputs with bus_cyc = 1 and go to BUSY. stallreq = 1, combinational, in this cycle.
- BUSY: hold all bus_* outputs stable; stallreq = 1; count cycles.
  - On bus_ack: capture the formatted load data, clear bus_cyc and bus_we, go to DONE.
  - When the counter reaches TIMEOUT_CYC with no ack: clear bus_cyc, pulse bus_err, mark the result invalid, go to DONE.
- DONE: stallreq = 0.
  - Loads: wb_wdata = latched data; wb_wreg = mem_wreg unless the result was invalidated by timeout or flush.
  - Always go to IDLE next cycle. The pipeline advances on this edge, so the same instruction is never reissued.

Latency:
- Load or store with ack in the first BUSY cycle: 3 cycles in stage (IDLE, BUSY, DONE).
- Each wait cycle adds 1.

Flush:
- In IDLE: no bus cycle starts.
- In BUSY: the transaction is not aborted. The unit waits for ack or timeout, then discards the result (wb_wreg = 0 in DONE).
- In DONE: wb_wreg = 0.

Simultaneous events:
- ack in the same cycle the timeout is reached: ack wins.
- flush together with ack: the data is discarded.

Decomposition:
- The `EXE_LB_OP..EXE_SW_OP` codes, the FSM state encodings, and the bus width constants go in defines.v.
- One combinational sub-module, mem_fmt, takes aluop, addr[1:0], reg2 and rdata. It produces sel, wdata, the formatted load data, and the misalign flags.

Test Plan:
- Passthrough ADDU, wd=5, wreg=1, wdata=0x1234 -> wb_* equal inputs in the same cycle; stallreq=0; bus_cyc=0.
- LW addr=0x100, ack after 2 wait cycles, rdata=0xDEADBEEF -> bus_cyc high for 3 cycles, sel=1111, stallreq high for 4 cycles; then wb_wdata=0xDEADBEEF, wb_wreg=1.
- LB addr=0x103, rdata=0x112233F0 -> sel=0001, wb_wdata=0xFFFFFFF0. LBU with the same stimulus -> wb_wdata=0x000000F0.
- SH addr=0x202, reg2=0x0000ABCD -> sel=0011, bus_wdata=0xABCDABCD, bus_we=1, wb_wreg=0.
- LW addr=0x101 -> exc_adel=1, bus_cyc=0, stallreq=0, wb_wreg=0.
- TIMEOUT_CYC=4, SW with no ack -> bus_cyc drops after 4 cycles, bus_err pulses for 1 cycle, stallreq releases. A second run with rst asserted mid-BUSY -> bus_cyc=0 the next cycle, FSM=IDLE.
